// File: rtl/vtg_pkg.sv
// Shared types and 1080p60 default timing for the video timing generator.
package vtg_pkg;

   // Phase of one raster axis, walked in this order and wrapping back to PH_ACTIVE.
   typedef enum logic [1:0] {
      PH_ACTIVE = 2'd0,
      PH_FP     = 2'd1,
      PH_SYNC   = 2'd2,
      PH_BP     = 2'd3
   } phase_e;

   localparam int unsigned VTG_H_ACTIVE = 1920;
   localparam int unsigned VTG_H_FP     = 88;
   localparam int unsigned VTG_H_SYNC   = 44;
   localparam int unsigned VTG_H_BP     = 148;
   localparam int unsigned VTG_V_ACTIVE = 1080;
   localparam int unsigned VTG_V_FP     = 4;
   localparam int unsigned VTG_V_SYNC   = 5;
   localparam int unsigned VTG_V_BP     = 36;
   localparam int unsigned VTG_CW       = 12;

endpackage

// File: rtl/vtg_axis_counter.sv
// One raster axis: position counter plus ACTIVE/FP/SYNC/BP phase tracker.
module vtg_axis_counter
   import vtg_pkg::*;
#(
   parameter int unsigned ACTIVE = VTG_H_ACTIVE,
   parameter int unsigned FP     = VTG_H_FP,
   parameter int unsigned SYNC   = VTG_H_SYNC,
   parameter int unsigned BP     = VTG_H_BP,
   parameter int unsigned CW     = VTG_CW
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          inc_i,
   output logic [CW-1:0] cnt_o,
   output phase_e        phase_o
);

   localparam int unsigned TOTAL = ACTIVE + FP + SYNC + BP;

   // Last position of each phase, fixed at elaboration.
   localparam logic [CW-1:0] LAST_ACTIVE = CW'(ACTIVE - 1);
   localparam logic [CW-1:0] LAST_FP     = CW'(ACTIVE + FP - 1);
   localparam logic [CW-1:0] LAST_SYNC   = CW'(ACTIVE + FP + SYNC - 1);
   localparam logic [CW-1:0] LAST_TOTAL  = CW'(TOTAL - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic          wrap_c;
   phase_e        phase_q;

   assign wrap_c = (cnt_q == LAST_TOTAL);

   // Next position: wrap to zero after the last position of the axis.
   always_comb begin
      cnt_d = cnt_q + CW'(1);
      if (wrap_c) begin
         cnt_d = '0;
      end
   end

   // Counter and phase advance together so the phase always matches the count.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q   <= '0;
         phase_q <= PH_ACTIVE;
      end else if (inc_i) begin
         cnt_q <= cnt_d;
         unique case (phase_q)
            PH_ACTIVE: if (cnt_q == LAST_ACTIVE) phase_q <= PH_FP;
            PH_FP:     if (cnt_q == LAST_FP)     phase_q <= PH_SYNC;
            PH_SYNC:   if (cnt_q == LAST_SYNC)   phase_q <= PH_BP;
            PH_BP:     if (cnt_q == LAST_TOTAL)  phase_q <= PH_ACTIVE;
            default:                             phase_q <= PH_ACTIVE;
         endcase
      end
   end

   assign cnt_o   = cnt_q;
   assign phase_o = phase_q;

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: registered coordinates, hsync, vsync, de and start pulses.
// Optional frame counter output is enabled by defining VTG_FRAME_COUNT_EN.
module video_timing_gen
   import vtg_pkg::*;
#(
   parameter int unsigned H_ACTIVE = VTG_H_ACTIVE,
   parameter int unsigned H_FP     = VTG_H_FP,
   parameter int unsigned H_SYNC   = VTG_H_SYNC,
   parameter int unsigned H_BP     = VTG_H_BP,
   parameter int unsigned V_ACTIVE = VTG_V_ACTIVE,
   parameter int unsigned V_FP     = VTG_V_FP,
   parameter int unsigned V_SYNC   = VTG_V_SYNC,
   parameter int unsigned V_BP     = VTG_V_BP,
   parameter bit          H_POL    = 1'b1,
   parameter bit          V_POL    = 1'b1,
   parameter int unsigned CW       = VTG_CW
) (
   input  logic          pixclk,
   input  logic          reset,
   input  logic          en,
   output logic [CW-1:0] counter_x,
   output logic [CW-1:0] counter_y,
   output logic          hsync,
   output logic          vsync,
   output logic          de,
   output logic          line_start,
   output logic          frame_start
`ifdef VTG_FRAME_COUNT_EN
   ,
   output logic [15:0]   frame_count
`endif
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;

   logic [CW-1:0] pos_x;
   logic [CW-1:0] pos_y;
   phase_e        h_phase;
   phase_e        v_phase;
   logic          h_wrap_c;
   logic          v_inc_c;

   assign h_wrap_c = (pos_x == CW'(H_TOTAL - 1));
   assign v_inc_c  = en & h_wrap_c;

   vtg_axis_counter #(
      .ACTIVE (H_ACTIVE),
      .FP     (H_FP),
      .SYNC   (H_SYNC),
      .BP     (H_BP),
      .CW     (CW)
   ) u_h_axis (
      .clk_i   (pixclk),
      .rst_ni  (reset),
      .inc_i   (en),
      .cnt_o   (pos_x),
      .phase_o (h_phase)
   );

   vtg_axis_counter #(
      .ACTIVE (V_ACTIVE),
      .FP     (V_FP),
      .SYNC   (V_SYNC),
      .BP     (V_BP),
      .CW     (CW)
   ) u_v_axis (
      .clk_i   (pixclk),
      .rst_ni  (reset),
      .inc_i   (v_inc_c),
      .cnt_o   (pos_y),
      .phase_o (v_phase)
   );

   logic [CW-1:0] counter_x_q, counter_x_d;
   logic [CW-1:0] counter_y_q, counter_y_d;
   logic          hsync_q, hsync_d;
   logic          vsync_q, vsync_d;
   logic          de_q, de_d;
   logic          line_start_q, line_start_d;
   logic          frame_start_q, frame_start_d;

   // Decode syncs and draw area from the axis phases for the current position.
   always_comb begin
      counter_x_d   = pos_x;
      counter_y_d   = pos_y;
      hsync_d       = ~H_POL;
      vsync_d       = ~V_POL;
      de_d          = (h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE);
      line_start_d  = (pos_x == '0);
      frame_start_d = (pos_x == '0) && (pos_y == '0);
      if (h_phase == PH_SYNC) hsync_d = H_POL;
      if (v_phase == PH_SYNC) vsync_d = V_POL;
   end

   // Output registers: one position of latency, frozen while en is low.
   always_ff @(posedge pixclk or negedge reset) begin
      if (!reset) begin
         counter_x_q   <= '0;
         counter_y_q   <= '0;
         hsync_q       <= ~H_POL;
         vsync_q       <= ~V_POL;
         de_q          <= 1'b0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else if (en) begin
         counter_x_q   <= counter_x_d;
         counter_y_q   <= counter_y_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         de_q          <= de_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign counter_x   = counter_x_q;
   assign counter_y   = counter_y_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign de          = de_q;
   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;

`ifdef VTG_FRAME_COUNT_EN
   logic [15:0] frame_count_q;

   // Frame counter steps on the same edge that registers frame_start high.
   always_ff @(posedge pixclk or negedge reset) begin
      if (!reset) begin
         frame_count_q <= '0;
      end else if (en && frame_start_d) begin
         frame_count_q <= frame_count_q + 16'd1;
      end
   end

   assign frame_count = frame_count_q;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench for video_timing_gen on a small raster (14 x 8).
module tb_video_timing_gen;
   import vtg_pkg::*;

   localparam int HA = 8, HF = 2, HS = 3, HB = 1;
   localparam int VA = 4, VF = 1, VS = 2, VB = 1;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;
   localparam int FT = HT * VT;
   localparam int CW = 12;

   logic pixclk = 1'b0;
   logic reset  = 1'b0;
   logic en     = 1'b0;

   logic [CW-1:0] px, py, nx, ny;
   logic p_hs, p_vs, p_de, p_ls, p_fs;
   logic n_hs, n_vs, n_de, n_ls, n_fs;
`ifdef VTG_FRAME_COUNT_EN
   logic [15:0] p_fc, n_fc;
`endif

   int checks   = 0;
   int failures = 0;
   int k        = 0;   // enabled edges since the last reset release

   always #5 pixclk = ~pixclk;

   video_timing_gen #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .H_POL(1'b1), .V_POL(1'b1), .CW(CW)
   ) dut (
      .pixclk(pixclk), .reset(reset), .en(en),
      .counter_x(px), .counter_y(py), .hsync(p_hs), .vsync(p_vs), .de(p_de),
      .line_start(p_ls), .frame_start(p_fs)
`ifdef VTG_FRAME_COUNT_EN
      , .frame_count(p_fc)
`endif
   );

   video_timing_gen #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .H_POL(1'b0), .V_POL(1'b0), .CW(CW)
   ) dut_n (
      .pixclk(pixclk), .reset(reset), .en(en),
      .counter_x(nx), .counter_y(ny), .hsync(n_hs), .vsync(n_vs), .de(n_de),
      .line_start(n_ls), .frame_start(n_fs)
`ifdef VTG_FRAME_COUNT_EN
      , .frame_count(n_fc)
`endif
   );

   // Expected outputs after kk enabled edges: the raster is a linear walk of FT positions.
   function automatic void model(input int kk, output int ex, output int ey, output bit de_e,
                                 output bit hs_e, output bit vs_e, output bit ls_e, output bit fs_e);
      int p;
      if (kk == 0) begin
         ex = 0; ey = 0; de_e = 0; hs_e = 0; vs_e = 0; ls_e = 0; fs_e = 0;
      end else begin
         p    = (kk - 1) % FT;
         ex   = p % HT;
         ey   = p / HT;
         de_e = (ex < HA) && (ey < VA);
         hs_e = (ex >= HA + HF) && (ex < HA + HF + HS);
         vs_e = (ey >= VA + VF) && (ey < VA + VF + VS);
         ls_e = (ex == 0);
         fs_e = (p == 0);
      end
   endfunction

   // Phase an axis position belongs to.
   function automatic phase_e phase_of(input int pos, input int a, input int f, input int s);
      if (pos < a)             return PH_ACTIVE;
      else if (pos < a + f)    return PH_FP;
      else if (pos < a + f + s) return PH_SYNC;
      else                     return PH_BP;
   endfunction

   // Expected frame_count: number of frame_start registrations since reset.
   function automatic int frames_of(input int kk);
      return (kk == 0) ? 0 : ((kk - 1) / FT) + 1;
   endfunction

   // One clock: drive en on the falling edge, sample 1 time unit after the rising edge.
   task automatic tick(input bit e);
      @(negedge pixclk);
      en = e;
      @(posedge pixclk);
      if (e && reset) k++;
      #1;
   endtask

   task automatic test_reset;
      reset = 1'b0;
      en    = 1'b1;
      repeat (3) @(posedge pixclk);
      #1;
      checks++; if (px !== '0 || py !== '0) begin failures++; $display("FAIL reset_xy got (%0d,%0d) exp (0,0)", px, py); end
      checks++; if (p_de !== 1'b0 || p_ls !== 1'b0 || p_fs !== 1'b0) begin failures++; $display("FAIL reset_flags got de=%b ls=%b fs=%b exp 0 0 0", p_de, p_ls, p_fs); end
      checks++; if (p_hs !== 1'b0 || p_vs !== 1'b0) begin failures++; $display("FAIL reset_sync got hs=%b vs=%b exp 0 0", p_hs, p_vs); end
      checks++; if (n_hs !== 1'b1 || n_vs !== 1'b1) begin failures++; $display("FAIL reset_sync_neg got hs=%b vs=%b exp 1 1", n_hs, n_vs); end
      @(negedge pixclk);
      en    = 1'b0;
      reset = 1'b1;
      k     = 0;
   endtask

   // Per-cycle comparison of both instances against the model, with random enable.
   task automatic test_raster(input int n, input int en_pct);
      int ex, ey;
      bit de_e, hs_e, vs_e, ls_e, fs_e;
      phase_e hp_e, vp_e;
      for (int i = 0; i < n; i++) begin
         tick($urandom_range(99) < en_pct);
         model(k, ex, ey, de_e, hs_e, vs_e, ls_e, fs_e);
         hp_e = phase_of((k % FT) % HT, HA, HF, HS);
         vp_e = phase_of((k % FT) / HT, VA, VF, VS);
         checks++; if (px !== CW'(ex) || py !== CW'(ey)) begin failures++; $display("FAIL raster_xy k=%0d got (%0d,%0d) exp (%0d,%0d)", k, px, py, ex, ey); end
         checks++; if (p_de !== de_e) begin failures++; $display("FAIL raster_de k=%0d got %b exp %b", k, p_de, de_e); end
         checks++; if (p_hs !== hs_e || p_vs !== vs_e) begin failures++; $display("FAIL raster_sync k=%0d got hs=%b vs=%b exp %b %b", k, p_hs, p_vs, hs_e, vs_e); end
         checks++; if (p_ls !== ls_e || p_fs !== fs_e) begin failures++; $display("FAIL raster_start k=%0d got ls=%b fs=%b exp %b %b", k, p_ls, p_fs, ls_e, fs_e); end
         checks++; if (n_hs !== !hs_e || n_vs !== !vs_e) begin failures++; $display("FAIL raster_neg_sync k=%0d got hs=%b vs=%b exp %b %b", k, n_hs, n_vs, !hs_e, !vs_e); end
         checks++; if (nx !== CW'(ex) || ny !== CW'(ey) || n_de !== de_e) begin failures++; $display("FAIL raster_neg_pos k=%0d got (%0d,%0d) de=%b exp (%0d,%0d) %b", k, nx, ny, n_de, ex, ey, de_e); end
         checks++; if (dut.u_h_axis.phase_q !== hp_e || dut.u_v_axis.phase_q !== vp_e) begin failures++; $display("FAIL raster_phase k=%0d got h=%0d v=%0d exp h=%0d v=%0d", k, dut.u_h_axis.phase_q, dut.u_v_axis.phase_q, hp_e, vp_e); end
      end
   endtask

   task automatic test_wrap;
      int ex, ey, fs_cnt;
      bit de_e, hs_e, vs_e, ls_e, fs_e, found;
      found = 0;
      for (int i = 0; i < FT + 2 && !found; i++) begin
         tick(1'b1);
         model(k, ex, ey, de_e, hs_e, vs_e, ls_e, fs_e);
         if (ex == HT - 1 && ey == VT - 1) found = 1;
      end
      checks++; if (!found || px !== CW'(HT - 1) || py !== CW'(VT - 1)) begin failures++; $display("FAIL wrap_last got (%0d,%0d) exp (%0d,%0d)", px, py, HT - 1, VT - 1); end
      tick(1'b1);
      checks++; if (px !== '0 || py !== '0) begin failures++; $display("FAIL wrap_first got (%0d,%0d) exp (0,0)", px, py); end
      checks++; if (p_fs !== 1'b1 || p_ls !== 1'b1 || p_de !== 1'b1) begin failures++; $display("FAIL wrap_flags got fs=%b ls=%b de=%b exp 1 1 1", p_fs, p_ls, p_de); end
      fs_cnt = 0;
      for (int i = 0; i < FT; i++) begin
         tick(1'b1);
         if (p_fs === 1'b1) fs_cnt++;
      end
      checks++; if (fs_cnt != 1) begin failures++; $display("FAIL wrap_fs_per_frame got %0d exp 1", fs_cnt); end
   endtask

   task automatic test_freeze;
      int ex, ey;
      bit de_e, hs_e, vs_e, ls_e, fs_e, found;
      found = 0;
      for (int i = 0; i < 2 * HT && !found; i++) begin
         tick(1'b1);
         model(k, ex, ey, de_e, hs_e, vs_e, ls_e, fs_e);
         if (ex == 9) found = 1;
      end
      checks++; if (!found || px !== CW'(9)) begin failures++; $display("FAIL freeze_setup got x=%0d exp 9", px); end
      for (int i = 0; i < 5; i++) begin
         tick(1'b0);
         checks++; if (px !== CW'(9) || py !== CW'(ey) || p_hs !== 1'b0 || p_de !== de_e || p_vs !== vs_e) begin failures++; $display("FAIL freeze_hold got (%0d,%0d) hs=%b de=%b vs=%b exp (9,%0d) 0 %b %b", px, py, p_hs, p_de, p_vs, ey, de_e, vs_e); end
      end
      tick(1'b1);
      checks++; if (px !== CW'(10) || py !== CW'(ey) || p_hs !== 1'b1) begin failures++; $display("FAIL freeze_resume got (%0d,%0d) hs=%b exp (10,%0d) 1", px, py, p_hs, ey); end
   endtask

   task automatic test_reset_mid;
      int ex, ey;
      bit de_e, hs_e, vs_e, ls_e, fs_e, found;
      found = 0;
      for (int i = 0; i < FT + 2 && !found; i++) begin
         tick(1'b1);
         model(k, ex, ey, de_e, hs_e, vs_e, ls_e, fs_e);
         if (ex == 6 && ey == 2) found = 1;
      end
      checks++; if (!found || px !== CW'(6) || py !== CW'(2)) begin failures++; $display("FAIL midrst_setup got (%0d,%0d) exp (6,2)", px, py); end
      #2;
      reset = 1'b0;
      k     = 0;
      #1;
      checks++; if (px !== '0 || py !== '0 || p_de !== 1'b0 || p_ls !== 1'b0 || p_fs !== 1'b0) begin failures++; $display("FAIL midrst_async got (%0d,%0d) de=%b ls=%b fs=%b exp (0,0) 0 0 0", px, py, p_de, p_ls, p_fs); end
      checks++; if (p_hs !== 1'b0 || p_vs !== 1'b0 || n_hs !== 1'b1 || n_vs !== 1'b1) begin failures++; $display("FAIL midrst_sync got %b%b %b%b exp 00 11", p_hs, p_vs, n_hs, n_vs); end
      tick(1'b1);
      checks++; if (px !== '0 || p_de !== 1'b0) begin failures++; $display("FAIL midrst_held got x=%0d de=%b exp 0 0", px, p_de); end
      @(negedge pixclk);
      en    = 1'b0;
      reset = 1'b1;
      tick(1'b1);
      checks++; if (px !== '0 || py !== '0 || p_de !== 1'b1 || p_fs !== 1'b1 || p_ls !== 1'b1) begin failures++; $display("FAIL midrst_first got (%0d,%0d) de=%b fs=%b ls=%b exp (0,0) 1 1 1", px, py, p_de, p_fs, p_ls); end
      tick(1'b1);
      checks++; if (px !== CW'(1) || p_fs !== 1'b0) begin failures++; $display("FAIL midrst_second got x=%0d fs=%b exp 1 0", px, p_fs); end
   endtask

`ifdef VTG_FRAME_COUNT_EN
   task automatic test_frame_count;
      bit found;
      @(negedge pixclk);
      en    = 1'b0;
      reset = 1'b0;
      k     = 0;
      @(negedge pixclk);
      checks++; if (p_fc !== 16'd0) begin failures++; $display("FAIL fc_reset got %0d exp 0", p_fc); end
      reset = 1'b1;
      for (int i = 0; i < 2 * FT + 1; i++) tick($urandom_range(99) < 90 ? 1'b1 : 1'b0);
      checks++; if (p_fc !== 16'(frames_of(k)) || n_fc !== 16'(frames_of(k))) begin failures++; $display("FAIL fc_count got %0d/%0d exp %0d", p_fc, n_fc, frames_of(k)); end
      while (frames_of(k) < 3) tick(1'b1);
      checks++; if (p_fc !== 16'd3) begin failures++; $display("FAIL fc_three got %0d exp 3", p_fc); end
      tick(1'b1);
      force dut.frame_count_q = 16'hFFFF;
      #1;
      release dut.frame_count_q;
      checks++; if (p_fc !== 16'hFFFF) begin failures++; $display("FAIL fc_preload got %0h exp ffff", p_fc); end
      found = 0;
      for (int i = 0; i < FT + 2 && !found; i++) begin
         tick(1'b1);
         if (p_fs === 1'b1) found = 1;
      end
      checks++; if (!found || p_fc !== 16'd0) begin failures++; $display("FAIL fc_wrap got %0h found=%b exp 0", p_fc, found); end
   endtask
`endif

   initial begin
      test_reset();
      test_raster(2 * FT, 100);
      test_wrap();
      test_freeze();
      test_raster(3 * FT, 70);
      test_reset_mid();
      test_raster(FT + 20, 85);
`ifdef VTG_FRAME_COUNT_EN
      test_frame_count();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
